// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_arb_pkg -- state encoding and defaults shared by uart_tx_arb
// Rev 1.0
// ------------------------------------------------------------------
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_CLR  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 2048;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick -- combinational round-robin search: first set req bit at or after ptr
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] N_L = (IW + 1)'(N);

  logic [IW:0] w_cand;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = {1'b0, ptr} + (IW + 1)'(k);
      if (w_cand >= N_L) begin
        w_cand = w_cand - N_L;
      end
      if (req[w_cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = w_cand[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_arb -- round-robin packet arbiter in front of one UART transmitter
// Optional watchdog: UART_TX_ARB_TIMEOUT_EN.   Rev 1.0
// ------------------------------------------------------------------
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       abort,
  output logic                       trmt,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       err
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gnt;
  logic [7:0]    r_tx_data;
  logic          r_last;
  logic          r_abort;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_gnt_next;
  logic          w_timeout;
  logic [7:0]    w_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_bytes[i] = req_data[8*i +: 8];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_gnt_next = (r_gnt == LAST_IDX) ? '0 : r_gnt + IW'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Counts cycles spent waiting on the transmitter for the current byte.
  assign w_timeout = ((r_state == WAIT_CLR) || (r_state == WAIT_DONE)) &&
                     (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == LOAD) begin
        r_cnt <= '0;
      end else if (w_timeout) begin
        r_cnt <= '0;
      end else if ((r_state == WAIT_CLR) || (r_state == WAIT_DONE)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_tx_data <= 8'h00;
      r_last    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_timeout) begin
        r_abort <= 1'b1;
        r_ptr   <= w_gnt_next;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_found) begin
              r_gnt     <= w_pick;
              r_tx_data <= w_bytes[w_pick];
              r_last    <= req_last[w_pick];
              r_state   <= LOAD;
            end
          end
          LOAD: begin
            r_state <= WAIT_CLR;
          end
          // The idle transmitter reports done; wait for it to start shifting first.
          WAIT_CLR: begin
            if (!tx_done) begin
              r_state <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (tx_done) begin
              if (r_last) begin
                r_ptr   <= w_gnt_next;
                r_state <= IDLE;
              end else if (req[r_gnt]) begin
                r_tx_data <= w_bytes[r_gnt];
                r_last    <= req_last[r_gnt];
                r_state   <= LOAD;
              end else begin
                r_abort <= 1'b1;
                r_ptr   <= w_gnt_next;
                r_state <= IDLE;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
    assign ack[i] = (r_state == LOAD) && (r_gnt == IW'(i));
  end

  assign trmt    = (r_state == LOAD);
  assign busy    = (r_state != IDLE);
  assign gnt_id  = r_gnt;
  assign tx_data = r_tx_data;
  assign abort   = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_tx_arb -- scoreboard bench for uart_tx_arb with a behavioural transmitter
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NUM_REQ  = 4;
  localparam int BYTE_CYC = 20;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_CYC = 50;
`else
  localparam int TO_CYC = 2048;
`endif

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   ack;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic                 abort;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 err;

  uart_tx_arb #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .abort    (abort),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .err      (err)
  );

  logic [8:0] stim_q [NUM_REQ][$];
  logic [7:0] exp_q  [NUM_REQ][$];
  int         exp_gnt [$];
  int         trmt_cyc [$];

  int                 n_checks;
  int                 n_errors;
  int                 cyc;
  int                 abort_cnt;
  logic [NUM_REQ-1:0] ack_prev;
  logic               tx_start;
  logic               tx_hold;
  int                 tx_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic present();
    logic [8:0] e;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stim_q[i].size() > 0) begin
        e                   = stim_q[i][0];
        req[i]              = 1'b1;
        req_data[8*i +: 8]  = e[7:0];
        req_last[i]         = e[8];
      end else begin
        req[i]              = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] data, input logic last);
    stim_q[id].push_back({last, data});
    exp_q[id].push_back(data);
    present();
  endtask

  task automatic tick();
    int         g;
    logic [7:0] eb;
    @(posedge clk);
    #1;
    cyc++;
    // transmitter: goes busy the cycle after trmt, done again BYTE_CYC cycles later
    if (tx_start) begin
      tx_start = 1'b0;
      if (!tx_hold) begin
        tx_done = 1'b0;
        tx_cnt  = BYTE_CYC;
      end
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (trmt) begin
      trmt_cyc.push_back(cyc);
      tx_start = 1'b1;
      if (exp_gnt.size() == 0) begin
        check_val("unexpected_trmt", 32'(trmt), 32'd0);
      end else begin
        g = exp_gnt.pop_front();
        check_val("gnt_id", 32'(gnt_id), g);
        check_val("ack_onehot", 32'(ack), 32'(1 << g));
        if (exp_q[g].size() == 0) begin
          check_val("byte_queue_size", exp_q[g].size(), 32'd1);
        end else begin
          eb = exp_q[g].pop_front();
          check_val("tx_data", 32'(tx_data), 32'(eb));
        end
      end
    end else begin
      check_val("ack_idle", 32'(ack), 32'd0);
    end
    if (abort) abort_cnt++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_prev[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
    end
    ack_prev = ack;
    present();
  endtask

  function automatic logic quiet();
    logic q;
    q = !busy && (exp_gnt.size() == 0) && (tx_cnt == 0) && !tx_start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stim_q[i].size() != 0) q = 1'b0;
    end
    return q;
  endfunction

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !quiet()) begin
      tick();
      n++;
    end
    check_val("idle_reached", 32'(quiet()), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_trmt(input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !trmt) begin
      tick();
      n++;
    end
    check_val("trmt_seen", 32'(trmt), 32'd1);
  endtask

  task automatic flush_bench();
    for (int i = 0; i < NUM_REQ; i++) begin
      stim_q[i].delete();
      exp_q[i].delete();
    end
    exp_gnt.delete();
    tx_start = 1'b0;
    tx_cnt   = 0;
    tx_done  = 1'b1;
    ack_prev = '0;
    present();
  endtask

  initial begin
    int a0;
    int t0;
    int n;
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    abort_cnt = 0;
    ack_prev  = '0;
    tx_start  = 1'b0;
    tx_hold   = 1'b0;
    tx_cnt    = 0;
    tx_done   = 1'b1;
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    req_last  = '0;

    repeat (3) tick();
    check_val("rst_trmt", 32'(trmt), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_gnt_id", 32'(gnt_id), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_abort", 32'(abort), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'h00);
    rst = 1'b0;
    tick();

    // single byte on requester 0, trmt one cycle after the request
    a0 = abort_cnt;
    push_byte(0, 8'hA5, 1'b1);
    exp_gnt.push_back(0);
    tick();
    check_val("t1_trmt_latency", 32'(trmt), 32'd1);
    tick();
    check_val("t1_trmt_pulse", 32'(trmt), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_tx_data_hold", 32'(tx_data), 32'hA5);
    wait_idle(200);
    check_val("t1_busy_low", 32'(busy), 32'd0);
    check_val("t1_no_abort", abort_cnt - a0, 32'd0);

    // three-byte packet on requester 2 keeps the grant while requester 1 waits
    trmt_cyc.delete();
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(2);
    exp_gnt.push_back(2);
    tick();
    push_byte(1, 8'h44, 1'b1);
    exp_gnt.push_back(1);
    wait_idle(400);
    check_val("t2_byte_count", trmt_cyc.size(), 32'd4);
    if (trmt_cyc.size() >= 3) begin
      check_val("t2_gap_b1_b2", trmt_cyc[1] - trmt_cyc[0], BYTE_CYC + 2);
      check_val("t2_gap_b2_b3", trmt_cyc[2] - trmt_cyc[1], BYTE_CYC + 2);
    end

    // requester 3 withdraws after a non-last byte
    a0 = abort_cnt;
    push_byte(3, 8'h55, 1'b0);
    exp_gnt.push_back(3);
    wait_idle(200);
    check_val("t3_abort_pulses", abort_cnt - a0, 32'd1);
    check_val("t3_busy_low", 32'(busy), 32'd0);

    // all four requesters, two single-byte packets each: order 0,1,2,3,0,1,2,3
    a0 = abort_cnt;
    for (int i = 0; i < NUM_REQ; i++) push_byte(i, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < NUM_REQ; i++) push_byte(i, 8'(8'h80 + i), 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) exp_gnt.push_back(i);
    end
    wait_idle(800);
    check_val("t4_no_abort", abort_cnt - a0, 32'd0);

    // move the pointer to 2, then reset in the middle of a byte
    push_byte(1, 8'h5A, 1'b1);
    exp_gnt.push_back(1);
    wait_idle(200);
    push_byte(2, 8'h66, 1'b0);
    push_byte(2, 8'h77, 1'b1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(2);
    wait_trmt(10);
    repeat (5) tick();
    check_val("t5_pre_busy", 32'(busy), 32'd1);
    check_val("t5_pre_gnt", 32'(gnt_id), 32'd2);
    rst = 1'b1;
    flush_bench();
    tick();
    check_val("t5_rst_trmt", 32'(trmt), 32'd0);
    check_val("t5_rst_ack", 32'(ack), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_gnt_id", 32'(gnt_id), 32'd0);
    check_val("t5_rst_tx_data", 32'(tx_data), 32'h00);
    rst = 1'b0;
    push_byte(3, 8'hAA, 1'b1);
    push_byte(1, 8'h99, 1'b1);
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    wait_idle(300);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // transmitter never starts: watchdog fires after TO_CYC waiting cycles
    tx_hold = 1'b1;
    a0 = abort_cnt;
    push_byte(0, 8'h12, 1'b1);
    exp_gnt.push_back(0);
    wait_trmt(10);
    t0 = cyc;
    n  = 0;
    while (!abort && n < 4 * TO_CYC) begin
      tick();
      n++;
    end
    check_val("to_latency", cyc - t0, TO_CYC + 1);
    check_val("to_err_set", 32'(err), 32'd1);
    repeat (5) tick();
    check_val("to_err_sticky", 32'(err), 32'd1);
    check_val("to_busy_low", 32'(busy), 32'd0);
    check_val("to_abort_pulses", abort_cnt - a0, 32'd1);
    rst = 1'b1;
    flush_bench();
    tick();
    rst     = 1'b0;
    tx_hold = 1'b0;
    check_val("to_err_cleared", 32'(err), 32'd0);
`else
    t0 = cyc;
    n  = 0;
    check_val("err_tied_low", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
